gnn_0_save_sched: RTL and testbench



---
 rtl/gnn_0_save_sched_if.sv | 31 +++
 rtl/gnn_0_save_sched.sv | 167 ++++++++++++++++
 tb/tb_gnn_0_save_sched.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gnn_0_save_sched_if.sv
// Instruction-in and save-engine bundle for the save scheduler.
// Handshakes:
//   inst_valid/inst_ready: a transfer happens on a rising aclk edge where both
//     are high; inst_data must be held while inst_valid is high and not
//     accepted. inst_ready depends only on registered queue state.
//   save_ap_start/save_ap_done: ap_start is a one-cycle pulse; ap_done is a
//     level the engine holds until the cycle after the next start.
interface gnn_0_save_sched_if #(
  parameter int SAVE_INST_LENGTH   = 96,
  parameter int C_M_AXI_ADDR_WIDTH = 64
);
  logic                          inst_valid;
  logic                          inst_ready;
  logic [SAVE_INST_LENGTH-1:0]   inst_data;
  logic                          save_ap_start;
  logic                          save_ap_done;
  logic [SAVE_INST_LENGTH-1:0]   save_ctrl_instruction;
  logic [C_M_AXI_ADDR_WIDTH-1:0] save_ctrl_addr_offset;

  // Dispatcher + engine side
  modport master (
    output inst_valid, inst_data, save_ap_done,
    input  inst_ready, save_ap_start, save_ctrl_instruction, save_ctrl_addr_offset
  );

  // Scheduler side
  modport slave (
    input  inst_valid, inst_data, save_ap_done,
    output inst_ready, save_ap_start, save_ctrl_instruction, save_ctrl_addr_offset
  );
endinterface

// File: rtl/gnn_0_save_sched.sv
// Save-engine scheduler: in-order instruction queue, dependency-token gating,
// one-at-a-time issue over ap_start/ap_done, retirement count and hang watchdog.
module gnn_0_save_sched #(
  parameter int SAVE_INST_LENGTH   = 96,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int FIFO_DEPTH         = 4,
  parameter int TIMEOUT_CYCLES     = 65535
) (
  input  logic                          aclk,
  input  logic                          areset,
  gnn_0_save_sched_if.slave             bus,
  input  logic                          dep_token,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_base,
  output logic                          retire_pulse,
  output logic [15:0]                   retire_count,
  output logic                          busy,
  output logic                          err_timeout,
  input  logic                          err_clear,
  output logic [2:0]                    o_dbg_state,
  output logic [3:0]                    o_dbg_tokens
);

  localparam int             PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]    PTR_ONE = (PW+1)'(1);
  localparam logic [19:0]    WD_LAST = 20'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_GUARD     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RETIRE    = 3'd4
  } state_t;

  state_t                        r_state;
  logic [SAVE_INST_LENGTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PW:0]                   r_wptr;
  logic [PW:0]                   r_rptr;
  logic [3:0]                    r_tokens;
  logic                          r_start;
  logic [SAVE_INST_LENGTH-1:0]   r_inst;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_offset;
  logic                          r_retire;
  logic [15:0]                   r_count;
  logic [19:0]                   r_wd;
  logic                          r_err;

  logic                          w_empty;
  logic                          w_full;
  logic                          w_push;
  logic [SAVE_INST_LENGTH-1:0]   w_head;
  logic                          w_skip;
  logic                          w_dispatch;
  logic                          w_pop;
  logic                          w_consume;
  logic                          w_timeout;

  // Extra pointer MSB distinguishes full from empty.
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_push     = bus.inst_valid && !w_full;
  assign w_head     = r_mem[r_rptr[PW-1:0]];

  // Zero-length heads retire without touching the engine or the tokens;
  // flagged heads otherwise wait for a token and block everything behind them.
  assign w_skip     = (r_state == S_IDLE) && !w_empty && (w_head[63:48] == 16'd0);
  assign w_dispatch = (r_state == S_IDLE) && !w_empty && (w_head[63:48] != 16'd0) &&
                      (!w_head[0] || (r_tokens != 4'd0));
  assign w_pop      = w_skip || w_dispatch;
  assign w_consume  = w_dispatch && w_head[0];
  assign w_timeout  = (r_state == S_WAIT_DONE) && !bus.save_ap_done && (r_wd == WD_LAST);

  // Queue storage; contents are don't-care until written.
  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= bus.inst_data;
  end

  // Queue pointers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Saturating dependency-token counter; arrival and consumption cancel.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_tokens <= 4'd0;
    end else begin
      case ({dep_token, w_consume})
        2'b10:   if (r_tokens != 4'hF) r_tokens <= r_tokens + 4'd1;
        2'b01:   r_tokens <= r_tokens - 4'd1;
        default: r_tokens <= r_tokens;
      endcase
    end
  end

  // Issue FSM with registered engine-facing and retirement outputs.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= S_IDLE;
      r_start  <= 1'b0;
      r_inst   <= '0;
      r_offset <= '0;
      r_retire <= 1'b0;
      r_count  <= 16'd0;
      r_wd     <= 20'd0;
    end else begin
      r_start  <= 1'b0;
      r_retire <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_skip) begin
            r_state  <= S_RETIRE;
            r_retire <= 1'b1;
            r_count  <= r_count + 16'd1;
          end else if (w_dispatch) begin
            r_state  <= S_START;
            r_start  <= 1'b1;
            r_inst   <= w_head;
            r_offset <= ctrl_addr_base;
          end
        end
        S_START: r_state <= S_GUARD;
        // Done may still be high from the previous instruction here.
        S_GUARD: begin
          r_state <= S_WAIT_DONE;
          r_wd    <= 20'd0;
        end
        S_WAIT_DONE: begin
          if (bus.save_ap_done || w_timeout) begin
            r_state  <= S_RETIRE;
            r_retire <= 1'b1;
            r_count  <= r_count + 16'd1;
          end else begin
            r_wd <= r_wd + 20'd1;
          end
        end
        S_RETIRE: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky hang flag; a new hang wins over a simultaneous clear.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)         r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
    else if (err_clear) r_err <= 1'b0;
  end

  assign bus.inst_ready            = !w_full;
  assign bus.save_ap_start         = r_start;
  assign bus.save_ctrl_instruction = r_inst;
  assign bus.save_ctrl_addr_offset = r_offset;
  assign retire_pulse              = r_retire;
  assign retire_count              = r_count;
  assign busy                      = (r_state != S_IDLE) || !w_empty;
  assign err_timeout               = r_err;
  assign o_dbg_state               = r_state;
  assign o_dbg_tokens              = r_tokens;

endmodule

// File: tb/tb_gnn_0_save_sched.sv
// Bench for gnn_0_save_sched: engine model, start/retire monitor with an
// expected-instruction queue, and one task per scenario.
module tb_gnn_0_save_sched;

  localparam int IW   = 96;
  localparam int AW   = 64;
  localparam int DEP  = 4;
  localparam int TMO  = 100;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd3;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  gnn_0_save_sched_if #(.SAVE_INST_LENGTH(IW), .C_M_AXI_ADDR_WIDTH(AW)) bus ();

  logic          dep_token;
  logic [AW-1:0] ctrl_addr_base;
  logic          retire_pulse;
  logic [15:0]   retire_count;
  logic          busy;
  logic          err_timeout;
  logic          err_clear;
  logic [2:0]    dbg_state;
  logic [3:0]    dbg_tokens;

  gnn_0_save_sched #(
    .SAVE_INST_LENGTH(IW), .C_M_AXI_ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .aclk(aclk), .areset(areset), .bus(bus),
    .dep_token(dep_token), .ctrl_addr_base(ctrl_addr_base),
    .retire_pulse(retire_pulse), .retire_count(retire_count),
    .busy(busy), .err_timeout(err_timeout), .err_clear(err_clear),
    .o_dbg_state(dbg_state), .o_dbg_tokens(dbg_tokens)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [IW+AW-1:0] exp_q[$];

  // ---------------- engine model ----------------
  // Done falls two cycles after the start cycle, so it is still high through
  // GUARD, and rises eng_delay cycles after start unless hanging.
  int eng_delay = 10;
  bit eng_hang  = 1'b0;
  int eng_cnt   = 0;
  int eng_drop  = 0;
  bit eng_active = 1'b0;

  always @(negedge aclk) begin
    if (areset) begin
      bus.save_ap_done = 1'b0;
      eng_active = 1'b0;
      eng_drop   = 0;
    end else if (bus.save_ap_start) begin
      eng_active = 1'b1;
      eng_cnt    = 0;
      eng_drop   = 2;
    end else begin
      if (eng_drop > 0) begin
        eng_drop--;
        if (eng_drop == 0) bus.save_ap_done = 1'b0;
      end
      if (eng_active) begin
        eng_cnt++;
        if (eng_cnt == eng_delay && !eng_hang) begin
          bus.save_ap_done = 1'b1;
          eng_active = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  int   since   = 0;
  bit   started = 1'b0;
  logic prev_start = 1'b0;

  always @(negedge aclk) begin
    logic [IW+AW-1:0] e;
    int exp_since;
    if (areset) begin
      started    = 1'b0;
      prev_start = 1'b0;
    end else begin
      since++;
      if (bus.save_ap_start) begin
        n_checks++;
        if (prev_start) begin
          $display("FAIL start_width: save_ap_start high two cycles in a row, t=%0t", $time);
          n_fail++;
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL start_unexpected: start with empty expected queue, inst=%h", bus.save_ctrl_instruction);
          n_fail++;
        end else begin
          e = exp_q.pop_front();
          if ({bus.save_ctrl_instruction, bus.save_ctrl_addr_offset} !== e) begin
            $display("FAIL start_payload: got %h/%h expected %h/%h",
                     bus.save_ctrl_instruction, bus.save_ctrl_addr_offset, e[IW+AW-1:AW], e[AW-1:0]);
            n_fail++;
          end
        end
        started = 1'b1;
        since   = 0;
      end
      if (retire_pulse && started) begin
        exp_since = eng_hang ? (TMO + 2) : (eng_delay + 1);
        n_checks++;
        if (since != exp_since) begin
          $display("FAIL retire_latency: %0d cycles after start, expected %0d", since, exp_since);
          n_fail++;
        end
        started = 1'b0;
      end
      prev_start = bus.save_ap_start;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [IW-1:0] mk_inst(input logic [15:0] len, input bit flag);
    logic [IW-1:0] d;
    d = {$urandom(), $urandom(), $urandom()};
    d[63:48] = len;
    d[0]     = flag;
    return d;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [IW-1:0] d);
    int n = 0;
    bus.inst_data  = d;
    bus.inst_valid = 1'b1;
    while (!bus.inst_ready && n < 400) begin
      @(negedge aclk);
      n++;
    end
    n_checks++;
    if (!bus.inst_ready) begin
      $display("FAIL push_accept: inst_ready=%b after %0d cycles, expected 1", bus.inst_ready, n);
      n_fail++;
    end else if (d[63:48] != 16'd0) begin
      exp_q.push_back({d, ctrl_addr_base});
    end
    @(negedge aclk);
    bus.inst_valid = 1'b0;
  endtask

  task automatic pulse_tokens(input int n);
    dep_token = 1'b1;
    repeat (n) @(negedge aclk);
    dep_token = 1'b0;
  endtask

  task automatic wait_retired(input logic [15:0] target, input int budget, input string name);
    int n = 0;
    while (retire_count !== target && n < budget) begin
      @(negedge aclk);
      n++;
    end
    n_checks++;
    if (retire_count !== target) begin
      $display("FAIL %s: retire_count=%0d, expected %0d", name, retire_count, target);
      n_fail++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_checks += 10;
    if (bus.inst_ready !== 1'b1)          begin $display("FAIL rst_ready: got %b expected 1", bus.inst_ready); n_fail++; end
    if (bus.save_ap_start !== 1'b0)       begin $display("FAIL rst_start: got %b expected 0", bus.save_ap_start); n_fail++; end
    if (bus.save_ctrl_instruction !== '0) begin $display("FAIL rst_inst: got %h expected 0", bus.save_ctrl_instruction); n_fail++; end
    if (bus.save_ctrl_addr_offset !== '0) begin $display("FAIL rst_offset: got %h expected 0", bus.save_ctrl_addr_offset); n_fail++; end
    if (retire_pulse !== 1'b0)            begin $display("FAIL rst_retire: got %b expected 0", retire_pulse); n_fail++; end
    if (retire_count !== 16'd0)           begin $display("FAIL rst_count: got %0d expected 0", retire_count); n_fail++; end
    if (busy !== 1'b0)                    begin $display("FAIL rst_busy: got %b expected 0", busy); n_fail++; end
    if (err_timeout !== 1'b0)             begin $display("FAIL rst_err: got %b expected 0", err_timeout); n_fail++; end
    if (dbg_state !== ST_IDLE)            begin $display("FAIL rst_state: got %0d expected 0", dbg_state); n_fail++; end
    if (dbg_tokens !== 4'd0)              begin $display("FAIL rst_tokens: got %0d expected 0", dbg_tokens); n_fail++; end
  endtask

  task automatic test_single();
    eng_delay      = 10;
    ctrl_addr_base = 64'h1234_5678_9abc_def0;
    push(mk_inst(16'd8, 1'b0));
    n_checks++;
    if (bus.save_ap_start !== 1'b0) begin $display("FAIL single_early: start=%b expected 0", bus.save_ap_start); n_fail++; end
    @(negedge aclk);
    n_checks++;
    if (bus.save_ap_start !== 1'b1) begin $display("FAIL single_start: start=%b expected 1", bus.save_ap_start); n_fail++; end
    wait_retired(16'd1, 40, "single_retire");
    @(negedge aclk);
    n_checks += 2;
    if (busy !== 1'b0)         begin $display("FAIL single_busy: got %b expected 0", busy); n_fail++; end
    if (retire_pulse !== 1'b0) begin $display("FAIL single_pulse_width: got %b expected 0", retire_pulse); n_fail++; end
  endtask

  task automatic test_back_to_back();
    eng_delay      = 6;
    ctrl_addr_base = 64'h0000_00a0_0000_4000;
    for (int i = 0; i < 5; i++) push(mk_inst(16'($urandom_range(1, 500)), 1'b0));
    n_checks++;
    if (bus.inst_ready !== 1'b0) begin $display("FAIL b2b_full: inst_ready=%b expected 0", bus.inst_ready); n_fail++; end
    wait_retired(16'd6, 200, "b2b_retire");
    n_checks++;
    if (exp_q.size() != 0) begin $display("FAIL b2b_drain: %0d pending, expected 0", exp_q.size()); n_fail++; end
    @(negedge aclk);
  endtask

  task automatic test_token_gating();
    int starts = 0;
    eng_delay = 4;
    push(mk_inst(16'd4, 1'b1));
    repeat (50) begin
      if (bus.save_ap_start) starts++;
      @(negedge aclk);
    end
    n_checks += 2;
    if (starts != 0)        begin $display("FAIL gate_block: %0d starts, expected 0", starts); n_fail++; end
    if (dbg_state !== ST_IDLE || busy !== 1'b1) begin
      $display("FAIL gate_idle: state=%0d busy=%b, expected 0/1", dbg_state, busy); n_fail++;
    end
    dep_token = 1'b1;
    @(negedge aclk);
    dep_token = 1'b0;
    n_checks++;
    if (bus.save_ap_start !== 1'b0) begin $display("FAIL gate_same_cycle: start=%b expected 0", bus.save_ap_start); n_fail++; end
    @(negedge aclk);
    n_checks += 2;
    if (bus.save_ap_start !== 1'b1) begin $display("FAIL gate_release: start=%b expected 1", bus.save_ap_start); n_fail++; end
    if (dbg_tokens !== 4'd0)        begin $display("FAIL gate_tokens: got %0d expected 0", dbg_tokens); n_fail++; end
    wait_retired(16'd7, 40, "gate_retire");
    @(negedge aclk);
  endtask

  task automatic test_token_saturation();
    eng_delay = 3;
    pulse_tokens(20);
    @(negedge aclk);
    n_checks++;
    if (dbg_tokens !== 4'd15) begin $display("FAIL sat_count: got %0d expected 15", dbg_tokens); n_fail++; end
    for (int i = 0; i < 16; i++) push(mk_inst(16'($urandom_range(1, 100)), 1'b1));
    wait_retired(16'd22, 200, "sat_fifteen");
    repeat (30) @(negedge aclk);
    n_checks += 3;
    if (retire_count !== 16'd22) begin $display("FAIL sat_block: retire_count=%0d expected 22", retire_count); n_fail++; end
    if (exp_q.size() != 1)       begin $display("FAIL sat_pending: %0d pending, expected 1", exp_q.size()); n_fail++; end
    if (dbg_tokens !== 4'd0)     begin $display("FAIL sat_empty: tokens=%0d expected 0", dbg_tokens); n_fail++; end
    pulse_tokens(1);
    wait_retired(16'd23, 40, "sat_release");
    @(negedge aclk);
  endtask

  task automatic test_zero_length();
    pulse_tokens(2);
    n_checks++;
    if (dbg_tokens !== 4'd2) begin $display("FAIL zero_tokens_pre: got %0d expected 2", dbg_tokens); n_fail++; end
    push(mk_inst(16'd0, 1'b1));
    n_checks++;
    if (retire_pulse !== 1'b0) begin $display("FAIL zero_early: retire_pulse=%b expected 0", retire_pulse); n_fail++; end
    @(negedge aclk);
    n_checks += 3;
    if (retire_pulse !== 1'b1)   begin $display("FAIL zero_retire: retire_pulse=%b expected 1", retire_pulse); n_fail++; end
    if (retire_count !== 16'd24) begin $display("FAIL zero_count: got %0d expected 24", retire_count); n_fail++; end
    if (dbg_tokens !== 4'd2)     begin $display("FAIL zero_tokens: got %0d expected 2", dbg_tokens); n_fail++; end
    @(negedge aclk);
    // Token arrival on the consuming dispatch edge leaves the count unchanged.
    eng_delay = 4;
    push(mk_inst(16'd5, 1'b1));
    dep_token = 1'b1;
    @(negedge aclk);
    dep_token = 1'b0;
    n_checks += 2;
    if (bus.save_ap_start !== 1'b1) begin $display("FAIL simul_start: start=%b expected 1", bus.save_ap_start); n_fail++; end
    if (dbg_tokens !== 4'd2)        begin $display("FAIL simul_tokens: got %0d expected 2", dbg_tokens); n_fail++; end
    wait_retired(16'd25, 40, "simul_retire");
    @(negedge aclk);
  endtask

  task automatic test_hang();
    eng_hang = 1'b1;
    push(mk_inst(16'd10, 1'b0));
    wait_retired(16'd26, 200, "hang_retire");
    n_checks++;
    if (err_timeout !== 1'b1) begin $display("FAIL hang_err: got %b expected 1", err_timeout); n_fail++; end
    @(negedge aclk);
    eng_hang  = 1'b0;
    eng_delay = 5;
    push(mk_inst(16'd7, 1'b0));
    wait_retired(16'd27, 40, "hang_next");
    n_checks++;
    if (err_timeout !== 1'b1) begin $display("FAIL hang_sticky: got %b expected 1", err_timeout); n_fail++; end
    @(negedge aclk);
    err_clear = 1'b1;
    @(negedge aclk);
    n_checks++;
    if (err_timeout !== 1'b0) begin $display("FAIL hang_clear: got %b expected 0", err_timeout); n_fail++; end
    // Clear held across a second hang: the set edge still wins.
    eng_hang = 1'b1;
    push(mk_inst(16'd12, 1'b0));
    wait_retired(16'd28, 200, "hang2_retire");
    n_checks++;
    if (err_timeout !== 1'b1) begin $display("FAIL hang_prio: got %b expected 1", err_timeout); n_fail++; end
    @(negedge aclk);
    n_checks++;
    if (err_timeout !== 1'b0) begin $display("FAIL hang_prio_clear: got %b expected 0", err_timeout); n_fail++; end
    err_clear = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    eng_hang = 1'b1;
    push(mk_inst(16'd9, 1'b0));
    while (dbg_state !== ST_WAIT && n < 20) begin @(negedge aclk); n++; end
    n_checks++;
    if (dbg_state !== ST_WAIT) begin $display("FAIL rmid_reach: state=%0d expected 3", dbg_state); n_fail++; end
    repeat (5) @(negedge aclk);
    areset = 1'b1;
    #1;
    test_reset();
    repeat (2) @(negedge aclk);
    areset   = 1'b0;
    eng_hang = 1'b0;
    eng_delay = 3;
    n_checks++;
    if (exp_q.size() != 0) begin $display("FAIL rmid_pending: %0d pending, expected 0", exp_q.size()); n_fail++; end
    push(mk_inst(16'd3, 1'b0));
    wait_retired(16'd1, 40, "rmid_resume");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    areset         = 1'b1;
    bus.inst_valid = 1'b0;
    bus.inst_data  = '0;
    dep_token      = 1'b0;
    err_clear      = 1'b0;
    ctrl_addr_base = '0;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    test_reset();
    test_single();
    test_back_to_back();
    test_token_gating();
    test_token_saturation();
    test_zero_length();
    test_hang();
    test_reset_mid();
    repeat (3) @(negedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #300000;
    $display("FAIL global_timeout: run exceeded time limit");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "time limit");
  end

endmodule
